// File: rtl/tp2_linebuf_writer.sv
// Toaplan2 line-buffer writer: one RGB888 RAM write per active pixel, plus line/frame status.
// Optional pixel CRC is built when TP2_LB_CRC_EN is defined; otherwise crc_o is tied to 0.
module tp2_linebuf_writer #(
   parameter int LB_LINES_LOG2 = 2,
   parameter int LINE_W        = 320
) (
   input  logic                      VCLK_i,
   input  logic                      RST_i,
   input  logic [4:0]                R_i,
   input  logic [4:0]                G_i,
   input  logic [4:0]                B_i,
   input  logic                      DE_i,
   input  logic [8:0]                xpos_i,
   input  logic [8:0]                ypos_i,
   input  logic                      frame_change_i,
   output logic                      wr_en_o,
   output logic [LB_LINES_LOG2+8:0]  wr_addr_o,
   output logic [23:0]               wr_data_o,
   output logic                      line_done_o,
   output logic [8:0]                line_id_o,
   output logic [8:0]                line_len_o,
   output logic                      frame_start_o,
   output logic [8:0]                lines_written_o,
   output logic                      len_err_o,
   output logic [15:0]               crc_o
);

   localparam logic [8:0] SAT    = 9'h1FF;
   localparam logic [8:0] LEN_OK = 9'(LINE_W);

   logic       de_p;
   logic [8:0] xpos_p;
   logic [8:0] ypos_p;
   logic       fc_p;
   logic [8:0] pix_cnt;

   logic new_pix;
   logic de_rise;
   logic de_fall;
   logic fc_rise;

   function automatic logic [7:0] expand(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   always_comb begin
      de_rise = DE_i & ~de_p;
      de_fall = de_p & ~DE_i;
      fc_rise = frame_change_i & ~fc_p;
      // a held pixel repeats xpos, so only a change (or a fresh line) writes
      new_pix = DE_i & (~de_p | (xpos_i != xpos_p));
   end

   always_ff @(posedge VCLK_i or posedge RST_i) begin
      if (RST_i) begin
         de_p            <= 1'b0;
         xpos_p          <= '0;
         ypos_p          <= '0;
         fc_p            <= 1'b0;
         pix_cnt         <= '0;
         wr_en_o         <= 1'b0;
         wr_addr_o       <= '0;
         wr_data_o       <= '0;
         line_done_o     <= 1'b0;
         line_id_o       <= '0;
         line_len_o      <= '0;
         frame_start_o   <= 1'b0;
         lines_written_o <= '0;
         len_err_o       <= 1'b0;
      end else begin
         de_p   <= DE_i;
         xpos_p <= xpos_i;
         ypos_p <= ypos_i;
         fc_p   <= frame_change_i;

         wr_en_o <= new_pix;
         if (new_pix) begin
            wr_addr_o <= {ypos_i[LB_LINES_LOG2-1:0], xpos_i};
            wr_data_o <= {expand(R_i), expand(G_i), expand(B_i)};
         end

         if (de_rise)
            pix_cnt <= 9'd1;
         else if (new_pix && pix_cnt != SAT)
            pix_cnt <= pix_cnt + 9'd1;

         line_done_o <= de_fall;
         if (de_fall) begin
            line_id_o  <= ypos_p;
            line_len_o <= pix_cnt;
            if (pix_cnt != LEN_OK)
               len_err_o <= 1'b1;
         end

         // frame start overrides a coincident line-end increment
         frame_start_o <= fc_rise;
         if (fc_rise)
            lines_written_o <= '0;
         else if (de_fall && lines_written_o != SAT)
            lines_written_o <= lines_written_o + 9'd1;
      end
   end

`ifdef TP2_LB_CRC_EN
   logic [15:0] crc_acc;
   logic [15:0] crc_nxt;

   function automatic logic [15:0] crc_step(
      input logic [15:0] c_in,
      input logic [14:0] d
   );
      logic [15:0] c;
      logic        fb;
      c = c_in;
      for (int i = 14; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   always_comb begin
      crc_nxt = crc_acc;
      if (new_pix)
         crc_nxt = crc_step(crc_acc, {R_i, G_i, B_i});
   end

   always_ff @(posedge VCLK_i or posedge RST_i) begin
      if (RST_i) begin
         crc_acc <= 16'hFFFF;
         crc_o   <= '0;
      end else if (fc_rise) begin
         crc_o   <= crc_nxt;
         crc_acc <= 16'hFFFF;
      end else begin
         crc_acc <= crc_nxt;
      end
   end
`else
   assign crc_o = '0;
`endif

endmodule

// File: tb/tb_tp2_linebuf_writer.sv
// Randomized line/frame stimulus for tp2_linebuf_writer against a frame-level model.
// Build with TP2_LB_CRC_EN defined to also check the frame CRC.
module tb_tp2_linebuf_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  r, g, b;
   logic        de;
   logic [8:0]  xpos, ypos;
   logic        fc;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [23:0] wr_data;
   logic        line_done;
   logic [8:0]  line_id, line_len;
   logic        frame_start;
   logic [8:0]  lines_written;
   logic        len_err;
   logic [15:0] crc;

   always #5 clk = ~clk;

   tp2_linebuf_writer #(.LB_LINES_LOG2(2), .LINE_W(320)) dut (
      .VCLK_i(clk), .RST_i(rst),
      .R_i(r), .G_i(g), .B_i(b), .DE_i(de),
      .xpos_i(xpos), .ypos_i(ypos), .frame_change_i(fc),
      .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .line_done_o(line_done), .line_id_o(line_id), .line_len_o(line_len),
      .frame_start_o(frame_start), .lines_written_o(lines_written),
      .len_err_o(len_err), .crc_o(crc)
   );

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc = 0;
   int ld_cyc = -2;
   int fs_cyc = -1;
   logic [34:0] wq[$];
   logic [17:0] ldq[$];

   int          m_lw = 0;
   bit          m_err = 1'b0;
   logic [15:0] m_crc = 16'h0;
   logic [14:0] fr_px[$];

   always @(negedge clk) begin
      cyc++;
      if (wr_en) wq.push_back({wr_addr, wr_data});
      if (line_done) begin
         ldq.push_back({line_id, line_len});
         ld_cyc = cyc;
      end
      if (frame_start) fs_cyc = cyc;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] expand(input logic [14:0] c);
      return {c[14:10], c[14:12], c[9:5], c[9:7], c[4:0], c[4:2]};
   endfunction

   function automatic logic [15:0] crc_frame();
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (fr_px[i])
         for (int k = 14; k >= 0; k--) begin
            fb = c[15] ^ fr_px[i][k];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      return c;
   endfunction

   function automatic logic [15:0] exp_crc();
`ifdef TP2_LB_CRC_EN
      return m_crc;
`else
      return 16'h0;
`endif
   endfunction

   task automatic status(input string tag);
      chk({tag, "_lines_written"}, lines_written, m_lw);
      chk({tag, "_len_err"}, len_err, m_err);
      chk({tag, "_crc"}, crc, exp_crc());
   endtask

   task automatic drive_line(input logic [8:0] y, input int x0, input int n,
                             input int hold, input bit fixed, input logic [14:0] fcol,
                             input bit fc_end, input bit check);
      logic [14:0] col;
      logic [34:0] ew[$];
      int          len;
      ld_cyc = -2;
      fs_cyc = -1;
      for (int i = 0; i < n; i++) begin
         col = fixed ? fcol : 15'($urandom);
         {r, g, b} = col;
         de = 1'b1;
         xpos = 9'(x0 + i);
         ypos = y;
         ew.push_back({y[1:0], 9'(x0 + i), expand(col)});
         fr_px.push_back(col);
         repeat (hold) tick();
      end
      de = 1'b0;
      if (fc_end) fc = 1'b1;
      len = (n > 511) ? 511 : n;
      if (len != 320) m_err = 1'b1;
      if (fc_end) begin
         m_crc = crc_frame();
         fr_px.delete();
         m_lw = 0;
      end else if (m_lw < 511) begin
         m_lw++;
      end
      repeat (4) tick();
      if (check) begin
         chk("wr_count", wq.size(), ew.size());
         for (int i = 0; i < wq.size() && i < ew.size(); i++)
            chk("wr_addr_data", wq[i], ew[i]);
         chk("line_done_count", ldq.size(), 1);
         if (ldq.size() > 0) chk("line_id_len", ldq[0], {y, 9'(len)});
         if (fc_end) chk("fs_same_cycle_as_ld", fs_cyc, ld_cyc);
         status("line");
      end
      wq.delete();
      ldq.delete();
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_line_done"}, line_done, 0);
      chk({tag, "_line_id"}, line_id, 0);
      chk({tag, "_line_len"}, line_len, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_lines_written"}, lines_written, 0);
      chk({tag, "_len_err"}, len_err, 0);
      chk({tag, "_crc"}, crc, 0);
   endtask

   initial begin
      rst = 1'b1;
      {r, g, b} = '0;
      de = 1'b0;
      xpos = '0;
      ypos = '0;
      fc = 1'b0;
      repeat (3) tick();
      outputs_zero("reset");
      rst = 1'b0;
      repeat (2) tick();

      // directed first line: R=1F G=0 B=10 -> FF0084, slot 1
      drive_line(9'd21, 0, 320, 2, 1'b1, 15'b11111_00000_10000, 1'b0, 1'b0);
      chk("first_line_len_err", len_err, 0);
      chk("first_line_id", line_id, 21);
      chk("first_line_len", line_len, 320);
      chk("first_line_lw", lines_written, m_lw);

      drive_line(9'd22, 0, 320, 2, 1'b1, 15'b11111_00000_10000, 1'b0, 1'b0);
      chk("fixed_data_last", wr_data, 24'hFF0084);
      chk("fixed_addr_last", wr_addr, {2'd2, 9'd319});

      drive_line(9'd23, 0, 319, 2, 1'b0, '0, 1'b0, 1'b1);
      chk("short_line_len", line_len, 319);
      drive_line(9'd24, 0, 320, 2, 1'b0, '0, 1'b0, 1'b1);
      chk("len_err_sticky", len_err, 1);

      for (int k = 0; k < 4; k++)
         drive_line(9'($urandom_range(0, 511)), 0, $urandom_range(300, 330),
                    $urandom_range(1, 3), 1'b0, '0, 1'b0, 1'b1);

      drive_line(9'd239, 0, 320, 2, 1'b0, '0, 1'b1, 1'b1);
      chk("lw_after_frame_start", lines_written, 0);

      // all-zero frame for the CRC
      drive_line(9'd0, 0, 320, 1, 1'b1, '0, 1'b0, 1'b1);
      chk("lw_first_line_of_frame", lines_written, 1);
      fc = 1'b0;
      drive_line(9'd1, 0, 320, 1, 1'b1, '0, 1'b0, 1'b1);
      drive_line(9'd2, 0, 320, 2, 1'b1, '0, 1'b0, 1'b1);
      fs_cyc = -1;
      fc = 1'b1;
      m_crc = crc_frame();
      fr_px.delete();
      m_lw = 0;
      repeat (3) tick();
      chk("gap_frame_start_seen", fs_cyc > 0, 1);
      status("gap_fs");
      fc = 1'b0;
      tick();

      for (int k = 0; k < 600; k++)
         drive_line(9'(k), 0, 2, 1, 1'b0, '0, 1'b0, 1'b0);
      chk("lw_saturated", lines_written, 511);
      status("sat");

      // reset mid-line at pixel 100, DE held high through reset
      for (int x = 0; x < 100; x++) begin
         {r, g, b} = 15'($urandom);
         de = 1'b1;
         xpos = 9'(x);
         ypos = 9'd50;
         repeat (2) tick();
      end
      xpos = 9'd100;
      tick();
      rst = 1'b1;
      #1;
      outputs_zero("async_reset");
      repeat (2) tick();
      wq.delete();
      ldq.delete();
      fr_px.delete();
      m_lw = 0;
      m_err = 1'b0;
      m_crc = 16'h0;
      rst = 1'b0;
      drive_line(9'd50, 100, 50, 2, 1'b0, '0, 1'b0, 1'b1);
      chk("post_reset_len_err", len_err, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
